snap_vacc_capture_ctrl: RTL and testbench



---
 rtl/snap_vacc_capture_ctrl.sv | 117 +++++++++++
 tb/tb_snap_vacc_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snap_vacc_capture_ctrl.sv
// Purpose: arms on a software edge, optionally waits for a trigger, then writes 2^ADDR_W samples to a capture BRAM.
// Latency: a sample qualified on cycle n is on the BRAM write port on cycle n+1; status/done track state with no lag.
// Backpressure: none; the BRAM always accepts, and unqualified samples (valid_sel=1, din_valid=0) are skipped.
module snap_vacc_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_word,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              arm_q;
    logic              primed;
    logic              trig_sel_q;
    logic              valid_sel_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] word_cnt_nxt;
    logic              arm_rise;
    logic              start;
    logic              wq;
    logic              issue;

    // primed stays low for the first clock after reset so that bit0 already
    // high at reset exit is taken as the old level, not as a fresh 0->1 edge.
    assign arm_rise = primed & ctrl_word[0] & ~arm_q;
    assign start    = trig_sel_q ? trig_in : 1'b1;
    assign wq       = valid_sel_q ? din_valid : 1'b1;

    // Next state and write-issue decision; a re-arm overrides any write this cycle.
    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        word_cnt_nxt = word_cnt;
        if (arm_rise) begin
            state_nxt    = ARMED;
            word_cnt_nxt = '0;
        end else begin
            case (state)
                ARMED: begin
                    if (start) begin
                        issue     = wq;
                        state_nxt = (wq && addr_cnt == LAST_ADDR) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    issue = wq;
                    if (wq && addr_cnt == LAST_ADDR) begin
                        state_nxt = DONE;
                    end
                end
                default: ;
            endcase
            if (issue && word_cnt != LAST_ADDR) begin
                word_cnt_nxt = word_cnt + ADDR_W'(1);
            end
        end
    end

    // State, counters and all registered outputs; status reflects the state being entered.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state       <= IDLE;
            arm_q       <= 1'b0;
            primed      <= 1'b0;
            trig_sel_q  <= 1'b0;
            valid_sel_q <= 1'b0;
            addr_cnt    <= '0;
            word_cnt    <= '0;
            bram_addr   <= '0;
            bram_data   <= '0;
            bram_we     <= 1'b0;
            done        <= 1'b0;
            status_word <= '0;
        end else begin
            primed      <= 1'b1;
            arm_q       <= ctrl_word[0];
            state       <= state_nxt;
            word_cnt    <= word_cnt_nxt;
            bram_we     <= issue;
            done        <= (state_nxt == DONE);
            status_word <= {state_nxt == DONE, state_nxt == ARMED, state_nxt == CAPTURE,
                            {(29 - ADDR_W){1'b0}}, word_cnt_nxt};
            if (arm_rise) begin
                trig_sel_q  <= ctrl_word[1];
                valid_sel_q <= ctrl_word[2];
                addr_cnt    <= '0;
                bram_addr   <= '0;
            end else if (issue) begin
                bram_addr <= addr_cnt;
                bram_data <= din;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Purpose: directed bench for the snapshot capture controller with a capture-session reference model.
// Latency: model predicts the BRAM port one cycle after each qualified sample; outputs compared every cycle.
// Backpressure: not applicable; stimulus is free-running directed vectors.
module tb_snap_vacc_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_CAP  = 2;
    localparam int P_FULL = 3;

    logic              clk;
    logic              rst_n;
    logic [31:0]       ctrl_word;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              trig_in;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status_word;
    logic              done;

    snap_vacc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .ctrl_word   (ctrl_word),
        .din         (din),
        .din_valid   (din_valid),
        .trig_in     (trig_in),
        .bram_addr   (bram_addr),
        .bram_data   (bram_data),
        .bram_we     (bram_we),
        .status_word (status_word),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample source: a distinct, cycle-tagged value each cycle.
    always @(negedge clk) din = 32'hA500_0000 + 32'(cyc);

    always @(posedge clk) cyc++;

    // Reference model: a capture session in terms of "last bit0 level seen",
    // "writes issued so far" and a phase; predicted port values after each edge.
    int              m_prev;
    int              m_phase;
    int              m_nwr;
    bit              m_tsel;
    bit              m_vsel;
    bit              e_we;
    int              e_addr;
    logic [31:0]     e_data;
    logic [31:0]     e_status;
    bit              e_done;

    initial begin
        m_prev = -1; m_phase = P_IDLE; m_nwr = 0; m_tsel = 0; m_vsel = 0;
        e_we = 0; e_addr = 0; e_data = '0; e_status = '0; e_done = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = -1; m_phase = P_IDLE; m_nwr = 0;
                e_we = 0; e_addr = 0; e_data = '0;
            end else begin
                e_we = 0;
                if (ctrl_word[0] && m_prev == 0) begin
                    m_tsel  = ctrl_word[1];
                    m_vsel  = ctrl_word[2];
                    m_phase = P_WAIT;
                    m_nwr   = 0;
                    e_addr  = 0;
                end else if (m_phase == P_WAIT || m_phase == P_CAP) begin
                    if (m_phase == P_CAP || !m_tsel || trig_in) begin
                        m_phase = P_CAP;
                        if (!m_vsel || din_valid) begin
                            e_we   = 1;
                            e_addr = m_nwr;
                            e_data = din;
                            m_nwr++;
                            if (m_nwr == DEPTH) m_phase = P_FULL;
                        end
                    end
                end
                m_prev = ctrl_word[0] ? 1 : 0;
            end
            e_done   = (m_phase == P_FULL);
            e_status = {m_phase == P_FULL, m_phase == P_WAIT, m_phase == P_CAP,
                        29'((m_nwr < DEPTH) ? m_nwr : DEPTH - 1)};
        end
    end

    // Per-cycle compare plus a write monitor feeding the literal checks.
    int          mon_wr = 0;
    int          mon_first_cyc = 0;
    int          mon_last_cyc = 0;
    logic [31:0] mon_first_data = '0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("bram_we", 32'(bram_we), 32'(e_we));
            check("bram_addr", 32'(bram_addr), 32'(e_addr));
            check("done", 32'(done), 32'(e_done));
            check("status_word", status_word, e_status);
            if (e_we) check("bram_data", bram_data, e_data);
            if (bram_we) begin
                mon_wr++;
                if (bram_addr == 0) begin
                    mon_first_cyc  = cyc;
                    mon_first_data = bram_data;
                end
                if (bram_addr == ADDR_W'(DEPTH - 1)) mon_last_cyc = cyc;
            end
        end
    end

    logic [31:0] trig_din;
    bit          found;

    initial begin
        rst_n = 1'b0; ctrl_word = '0; din_valid = 1'b0; trig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", status_word, 32'h0);
        check("rst_we", 32'(bram_we), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Free-running capture: 16 consecutive writes.
        mon_wr = 0;
        ctrl_word = 32'h1;
        repeat (20) @(negedge clk);
        check("t1_writes", 32'(mon_wr), 32'd16);
        check("t1_span", 32'(mon_last_cyc - mon_first_cyc), 32'd15);
        check("t1_status", status_word, 32'h8000_000F);
        check("t1_done", 32'(done), 32'h1);

        // Triggered capture; upper control bits carry junk.
        ctrl_word = 32'hDEAD_BEE8;
        @(negedge clk);
        mon_wr = 0;
        ctrl_word = 32'hDEAD_BEEB;
        repeat (20) @(negedge clk);
        check("t2_no_write_before_trig", 32'(mon_wr), 32'd0);
        check("t2_armed_status", status_word, 32'h4000_0000);
        trig_in = 1'b1;
        #1 trig_din = din;
        @(negedge clk);
        trig_in = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_first_data", mon_first_data, trig_din);
        check("t2_writes", 32'(mon_wr), 32'd16);

        // Valid-qualified capture with din_valid alternating.
        ctrl_word = 32'h0;
        @(negedge clk);
        mon_wr = 0;
        ctrl_word = 32'h5;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            din_valid = ~din_valid;
        end
        din_valid = 1'b0;
        check("t3_writes", 32'(mon_wr), 32'd16);
        check("t3_span", 32'(mon_last_cyc - mon_first_cyc), 32'd30);
        check("t3_status", status_word, 32'h8000_000F);

        // Re-arm while the write to address 7 is on the port.
        ctrl_word = 32'h0;
        @(negedge clk);
        ctrl_word = 32'h1;
        @(negedge clk);
        ctrl_word = 32'h0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bram_we && bram_addr == 4'd7) found = 1;
        end
        check("t4_reached_addr7", 32'(found), 32'h1);
        ctrl_word = 32'h1;
        @(posedge clk);
        #3;
        check("t4_rearm_we", 32'(bram_we), 32'h0);
        check("t4_rearm_addr", 32'(bram_addr), 32'h0);
        check("t4_rearm_done", 32'(done), 32'h0);
        check("t4_rearm_status", status_word, 32'h4000_0000);
        mon_wr = 0;
        repeat (20) @(negedge clk);
        check("t4_fresh_writes", 32'(mon_wr), 32'd16);
        check("t4_fresh_status", status_word, 32'h8000_000F);

        // Asynchronous reset in the middle of a capture.
        ctrl_word = 32'h0;
        @(negedge clk);
        ctrl_word = 32'h1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        check("t5_we_before_rst", 32'(bram_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(bram_we), 32'h0);
        check("t5_rst_done", 32'(done), 32'h0);
        check("t5_rst_status", status_word, 32'h0);
        repeat (2) @(negedge clk);
        mon_wr = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_arm_held_high", status_word, 32'h0);
        check("t5_no_writes", 32'(mon_wr), 32'd0);
        ctrl_word = 32'h0;
        @(negedge clk);
        ctrl_word = 32'h1;
        repeat (20) @(negedge clk);
        check("t5_after_edge_status", status_word, 32'h8000_000F);
        check("t5_after_edge_writes", 32'(mon_wr), 32'd16);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
